i2c_target_regfile: RTL and testbench
=====================================

# i2c_target_regfile

I2C target (responder) with a small byte-wide register file. It answers the register write and register read transactions issued by the team's AXI-to-I2C initiator, and can stand in for the sensor on-board or in simulation. It oversamples SCL/SDA on the system clock, decodes START/STOP/address/pointer/data, and drives ACK and read data open-drain. A local port lets sensor logic update measurement registers and observe I2C writes.

## Interface
- `DEV_ADDR`, default 8'h77: the target answers the 7-bit address `DEV_ADDR[7:1]` (7'h3B); bit 0 is ignored.
- `NREG`, default 16: number of implemented registers, 1..256.
- `FILTER`, default 3: consecutive identical clk samples required to accept an SCL/SDA level change.
- `clk` input 1: system clock (83 MHz).
- `rst` input 1: reset, synchronous, active-high.
- `scl` input 1: bus clock, raw.
- `sda_in` input 1: bus data, raw.
- `sda_out` output 1: value driven when `sda_sel`=1; constant 0 (open-drain).
- `sda_sel` output 1: 1 means the target pulls SDA low; 0 means SDA is released.
- `upd_valid` input 1: local register update strobe.
- `upd_addr` input 8: local update address.
- `upd_data` input 8: local update data.
- `wr_valid` output 1: one-cycle pulse when an I2C write byte is committed.
- `wr_addr` output 8: register pointer of the committed write.
- `wr_data` output 8: data of the committed write.
- `busy` output 1: addressed transaction in progress (ACKed address up to STOP).

## Operation
- **Input conditioning.**
  - 2-flop synchronizer on `scl` and `sda_in`, then the FILTER-sample glitch filter, giving `scl_f` and `sda_f`.
  - Edges are detected on the filtered signals only.
- **Bus conditions.**
  - START or repeated START: falling `sda_f` while `scl_f`=1.
  - STOP: rising `sda_f` while `scl_f`=1.
  - START from any state goes to ADDR and clears the bit counter.
  - STOP from any state goes to IDLE, releases SDA and clears `busy`.
- **Bit timing.** Bits are sampled MSB-first on rising `scl_f`. The target changes `sda_sel` only on falling `scl_f`.
- **States:**
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If bits[7:1] = `DEV_ADDR[7:1]`, go to ADDR_ACK and latch the R/W bit.
    - Otherwise go to IGNORE.
  - ADDR_ACK: drive 0 for the 9th clock.
    - R/W=0: go to PTR.
    - R/W=1: go to RDATA.
  - PTR: shift 8 bits into the pointer, then go to PTR_ACK (always ACK). Then go to WDATA.
  - WDATA: shift 8 bits, then go to WDATA_ACK.
    - At the 8th rising edge, write the register and pulse `wr_valid`.
    - Always ACK, then return to WDATA.
  - RDATA: load the shift register from `reg[ptr]` at the falling edge that ends the ACK, then drive 8 bits.
    - Driving a bit: a 0 sets `sda_sel`=1; a 1 releases SDA.
  - RDATA_ACK: release SDA and sample the initiator's ACK.
    - ACK (0): reload and go to RDATA.
    - NACK (1): go to IGNORE.
  - IGNORE: SDA released; wait for START/STOP.
- **Pointer rules.**
  - Pointer is 8 bits.
  - Pointer ≥ NREG: writes are ACKed and discarded (no `wr_valid`); reads return 8'hFF.
  - The pointer persists across transactions until the next PTR phase.
- **Local update.** When `upd_valid`=1 and `upd_addr` < NREG, write `upd_data` to that register.
  - If an I2C write hits the same register in the same cycle, the I2C write wins and the update is dropped.
  - An update after the RDATA load does not alter the byte in flight.
- **Reset values.** All registers 8'h00; `sda_sel` 0; `sda_out` 0; `wr_valid` 0; `wr_addr` 0; `wr_data` 0; `busy` 0; state IDLE; pointer 0.
- **Reset mid-operation.** SDA is released on the first clk edge with `rst`=1. No partial write is committed.

## Timing
- Input path latency: 2 sync cycles plus FILTER cycles from a pad change to the filtered edge (5 clk at defaults).
- `sda_sel` updates 1 clk after the filtered falling SCL edge.
- `wr_valid` pulses for 1 clk, 1 clk after the 8th filtered rising SCL edge of a data byte. `wr_addr`/`wr_data` are held until the next pulse.
- `busy` rises 1 clk after the address match and falls 1 clk after STOP or a NACKed read.
- SCL low time must exceed the input path latency plus 1 clk; the initiator's ~1.6 ms bit time satisfies this.

## Configuration
- `I2C_TARGET_AUTOINC_EN` defined: the pointer increments (wrapping 8'hFF→8'h00) after each committed write byte and after each read byte's ACK/NACK. This enables burst reads and writes.
- Not defined: the pointer is fixed for the whole transaction. Repeated bytes re-read or re-write the same register.

## Test plan
- Write 0x3B/W, ptr 0x03, data 0x5A, STOP -> three ACKs (`sda_sel`=1 on each 9th clock); `wr_valid` pulse with `wr_addr`=0x03, `wr_data`=0x5A; `busy` 0 after STOP.
- Set `upd_addr`=0x05, `upd_data`=0xC3; then 0x3B/W, ptr 0x05, repeated START, 0x3B/R, NACK, STOP -> bits 1100_0011 observed on SDA; `busy` cleared at NACK.
- Address 0x50/W followed by bytes -> `sda_sel` never asserted; no `wr_valid`; state returns to IDLE at STOP.
- Read at ptr 0x20 with NREG=16 -> 0xFF returned; write at ptr 0x20 -> ACKed, no `wr_valid`.
- Assert `rst` while driving a 0 read bit -> `sda_sel`=0 next clk; read of reg 0x05 afterwards returns 0x00.
- 2-clk SDA low pulse while SCL high -> no START/STOP detected. With `I2C_TARGET_AUTOINC_EN`: burst write 0x11, 0x22 at ptr 0x07 -> reg 7=0x11, reg 8=0x22.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file.
// Oversamples SCL/SDA on clk, decodes START/STOP/address/pointer/data and
// drives ACK and read data open-drain. A local port updates registers and
// reports I2C writes.
// Optional feature macro: I2C_TARGET_AUTOINC_EN (pointer auto-increment).
module i2c_target_regfile #(
  parameter logic [7:0]  DEV_ADDR = 8'h77,
  parameter int unsigned NREG     = 16,
  parameter int unsigned FILTER   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_sel,
  input  logic       upd_valid,
  input  logic [7:0] upd_addr,
  input  logic [7:0] upd_data,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam int unsigned FCW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int unsigned AW  = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] PTR       = 4'd3;
  localparam logic [3:0] PTR_ACK   = 4'd4;
  localparam logic [3:0] WDATA     = 4'd5;
  localparam logic [3:0] WDATA_ACK = 4'd6;
  localparam logic [3:0] RDATA     = 4'd7;
  localparam logic [3:0] RDATA_ACK = 4'd8;
  localparam logic [3:0] IGNORE    = 4'd9;

  // bit 1 = SCL, bit 0 = SDA
  logic [1:0]     sync1, sync2, filt, filt_q;
  logic [FCW-1:0] fcnt [2];

  logic [7:0] regs [NREG];

  logic [3:0] state, state_nxt;
  logic [3:0] bcnt, bcnt_nxt;
  logic [6:0] sh, sh_nxt;
  logic [7:0] ptr, ptr_nxt;
  logic       phase, phase_nxt;
  logic       rw, rw_nxt;
  logic       sda_sel_nxt, busy_nxt, wr_valid_nxt;
  logic [7:0] wr_addr_nxt, wr_data_nxt;

  logic          scl_f, sda_f;
  logic          scl_rise_c, scl_fall_c, start_c, stop_c;
  logic          ptr_ok_c, upd_ok_c, wr_en_c;
  logic [7:0]    byte_c, rd_byte_c;
  logic [AW-1:0] ptr_idx_c, upd_idx_c;

  assign sda_out = 1'b0;

  // Synchronize both bus lines, then accept a level only after FILTER stable samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1  <= {scl, sda_in};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILTER - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCW'(1);
        end
      end
    end
  end

  assign scl_f      = filt[1];
  assign sda_f      = filt[0];
  assign scl_rise_c = scl_f & ~filt_q[1];
  assign scl_fall_c = ~scl_f & filt_q[1];
  assign start_c    = scl_f & filt_q[1] & ~sda_f & filt_q[0];
  assign stop_c     = scl_f & filt_q[1] & sda_f & ~filt_q[0];

  assign byte_c    = {sh, sda_f};
  assign ptr_ok_c  = 32'(ptr) < NREG;
  assign upd_ok_c  = 32'(upd_addr) < NREG;
  assign ptr_idx_c = ptr[AW-1:0];
  assign upd_idx_c = upd_addr[AW-1:0];
  assign rd_byte_c = ptr_ok_c ? regs[ptr_idx_c] : 8'hFF;

  // Register file: local update first so a same-cycle I2C write overrides it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= 8'h00;
    end else begin
      if (upd_valid && upd_ok_c) regs[upd_idx_c] <= upd_data;
      if (wr_en_c) regs[ptr_idx_c] <= byte_c;
    end
  end

  // Protocol state register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bcnt     <= '0;
      sh       <= '0;
      ptr      <= '0;
      phase    <= 1'b0;
      rw       <= 1'b0;
      sda_sel  <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_nxt;
      bcnt     <= bcnt_nxt;
      sh       <= sh_nxt;
      ptr      <= ptr_nxt;
      phase    <= phase_nxt;
      rw       <= rw_nxt;
      sda_sel  <= sda_sel_nxt;
      busy     <= busy_nxt;
      wr_valid <= wr_valid_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
    end
  end

  // Next-state: bus conditions take priority over SCL edges
  always_comb begin
    state_nxt    = state;
    bcnt_nxt     = bcnt;
    sh_nxt       = sh;
    ptr_nxt      = ptr;
    phase_nxt    = phase;
    rw_nxt       = rw;
    sda_sel_nxt  = sda_sel;
    busy_nxt     = busy;
    wr_valid_nxt = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    wr_en_c      = 1'b0;

    if (start_c) begin
      state_nxt   = ADDR;
      bcnt_nxt    = '0;
      phase_nxt   = 1'b0;
      sda_sel_nxt = 1'b0;
    end else if (stop_c) begin
      state_nxt   = IDLE;
      bcnt_nxt    = '0;
      phase_nxt   = 1'b0;
      sda_sel_nxt = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE, IGNORE: ;

        ADDR: if (scl_rise_c) begin
          sh_nxt = {sh[5:0], sda_f};
          if (bcnt == 4'd7) begin
            bcnt_nxt  = '0;
            phase_nxt = 1'b0;
            if (sh == DEV_ADDR[7:1]) begin
              state_nxt = ADDR_ACK;
              rw_nxt    = sda_f;
              busy_nxt  = 1'b1;
            end else begin
              state_nxt = IGNORE;
              busy_nxt  = 1'b0;
            end
          end else begin
            bcnt_nxt = bcnt + 4'd1;
          end
        end

        // First falling edge drives ACK low, second one ends the 9th clock
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall_c) begin
          if (!phase) begin
            sda_sel_nxt = 1'b1;
            phase_nxt   = 1'b1;
          end else begin
            phase_nxt   = 1'b0;
            bcnt_nxt    = '0;
            sda_sel_nxt = 1'b0;
            if (state == ADDR_ACK && rw) begin
              state_nxt   = RDATA;
              sh_nxt      = rd_byte_c[6:0];
              sda_sel_nxt = ~rd_byte_c[7];
            end else if (state == ADDR_ACK) begin
              state_nxt = PTR;
            end else begin
              state_nxt = WDATA;
            end
          end
        end

        PTR: if (scl_rise_c) begin
          sh_nxt = {sh[5:0], sda_f};
          if (bcnt == 4'd7) begin
            ptr_nxt   = byte_c;
            bcnt_nxt  = '0;
            phase_nxt = 1'b0;
            state_nxt = PTR_ACK;
          end else begin
            bcnt_nxt = bcnt + 4'd1;
          end
        end

        WDATA: if (scl_rise_c) begin
          sh_nxt = {sh[5:0], sda_f};
          if (bcnt == 4'd7) begin
            if (ptr_ok_c) begin
              wr_en_c      = 1'b1;
              wr_valid_nxt = 1'b1;
              wr_addr_nxt  = ptr;
              wr_data_nxt  = byte_c;
            end
            if (AUTOINC) ptr_nxt = ptr + 8'd1;
            bcnt_nxt  = '0;
            phase_nxt = 1'b0;
            state_nxt = WDATA_ACK;
          end else begin
            bcnt_nxt = bcnt + 4'd1;
          end
        end

        RDATA: begin
          if (scl_rise_c) begin
            bcnt_nxt = bcnt + 4'd1;
          end else if (scl_fall_c) begin
            if (bcnt == 4'd8) begin
              state_nxt   = RDATA_ACK;
              sda_sel_nxt = 1'b0;
              bcnt_nxt    = '0;
              phase_nxt   = 1'b0;
            end else begin
              sda_sel_nxt = ~sh[6];
              sh_nxt      = {sh[5:0], 1'b1};
            end
          end
        end

        // Initiator ACK keeps the read going; NACK ends the transaction
        RDATA_ACK: begin
          if (scl_rise_c) begin
            if (AUTOINC) ptr_nxt = ptr + 8'd1;
            if (sda_f) begin
              state_nxt = IGNORE;
              busy_nxt  = 1'b0;
            end else begin
              phase_nxt = 1'b1;
            end
          end else if (scl_fall_c && phase) begin
            state_nxt   = RDATA;
            phase_nxt   = 1'b0;
            bcnt_nxt    = '0;
            sh_nxt      = rd_byte_c[6:0];
            sda_sel_nxt = ~rd_byte_c[7];
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bit-banged I2C initiator on a
// wired-AND SDA line, immediate assertions at each comparison point.
module tb_i2c_target_regfile;

  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       tb_sda = 1'b1;
  logic       upd_valid = 1'b0;
  logic [7:0] upd_addr = 8'h00;
  logic [7:0] upd_data = 8'h00;
  logic       sda_out, sda_sel, wr_valid, busy;
  logic [7:0] wr_addr, wr_data;
  logic       sda_line;

  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;
  int         sel_cnt = 0;
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_data = 8'h00;

  assign sda_line = tb_sda & (sda_sel ? sda_out : 1'b1);

  i2c_target_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_line),
    .sda_out   (sda_out),
    .sda_sel   (sda_sel),
    .upd_valid (upd_valid),
    .upd_addr  (upd_addr),
    .upd_data  (upd_data),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Record committed writes and any cycle the target pulls SDA
  always @(negedge clk) begin
    if (wr_valid) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (sda_sel) sel_cnt <= sel_cnt + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    tb_sda = 1'b1; wq();
    scl = 1'b1;    wq();
    tb_sda = 1'b0; wq();
    scl = 1'b0;    wq();
  endtask

  task automatic i2c_stop();
    tb_sda = 1'b0; wq();
    scl = 1'b1;    wq();
    tb_sda = 1'b1; wq(); wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      tb_sda = b[i]; wq();
      scl = 1'b1;    wq(); wq();
      scl = 1'b0;    wq();
    end
    tb_sda = 1'b1; wq();
    scl = 1'b1;    wq();
    ack = sda_sel;
    wq();
    scl = 1'b0;    wq();
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
    d = 8'h00;
    tb_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wq();
      scl = 1'b1; wq();
      d = {d[6:0], sda_line};
      wq();
      scl = 1'b0; wq();
    end
    tb_sda = ack_bit; wq();
    scl = 1'b1;       wq(); wq();
    scl = 1'b0;       wq();
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         wr0, sel0;

    // Reset values
    repeat (5) @(negedge clk);
    chk("rst_sda_sel", sda_sel, 0);
    chk("rst_sda_out", sda_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Register write 0x5A to ptr 0x03
    i2c_start();
    send_byte(8'h76, ack); chk("w1_addr_ack", ack, 1);
    chk("w1_busy", busy, 1);
    send_byte(8'h03, ack); chk("w1_ptr_ack", ack, 1);
    send_byte(8'h5A, ack); chk("w1_data_ack", ack, 1);
    chk("w1_wr_cnt", wr_cnt, 1);
    chk("w1_wr_addr", last_addr, 8'h03);
    chk("w1_wr_data", last_data, 8'h5A);
    i2c_stop();
    chk("w1_busy_after_stop", busy, 0);

    // Local update of reg 5, then read it back with a repeated START
    upd_addr = 8'h05; upd_data = 8'hC3; upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    i2c_start();
    send_byte(8'h76, ack); chk("r1_addr_ack", ack, 1);
    send_byte(8'h05, ack); chk("r1_ptr_ack", ack, 1);
    i2c_start();
    send_byte(8'h77, ack); chk("r1_raddr_ack", ack, 1);
    recv_byte(1'b1, rd);   chk("r1_data", rd, 8'hC3);
    chk("r1_busy_after_nack", busy, 0);
    i2c_stop();
    chk("r1_no_wr", wr_cnt, 1);

    // Foreign address: never ACKed, never written
    sel0 = sel_cnt; wr0 = wr_cnt;
    i2c_start();
    send_byte(8'hA0, ack); chk("x_addr_nack", ack, 0);
    send_byte(8'h03, ack); chk("x_b1_nack", ack, 0);
    send_byte(8'h34, ack); chk("x_b2_nack", ack, 0);
    chk("x_busy", busy, 0);
    chk("x_sel_never", sel_cnt - sel0, 0);
    i2c_stop();
    chk("x_no_wr", wr_cnt - wr0, 0);
    chk("x_idle", dut.state, 0);

    // Out-of-range pointer: write ACKed and discarded, read returns 0xFF
    wr0 = wr_cnt;
    i2c_start();
    send_byte(8'h76, ack); chk("oor_addr_ack", ack, 1);
    send_byte(8'h20, ack); chk("oor_ptr_ack", ack, 1);
    send_byte(8'h99, ack); chk("oor_data_ack", ack, 1);
    i2c_stop();
    chk("oor_no_wr", wr_cnt - wr0, 0);
    i2c_start();
    send_byte(8'h77, ack); chk("oor_raddr_ack", ack, 1);
    recv_byte(1'b1, rd);   chk("oor_rdata", rd, 8'hFF);
    i2c_stop();

    // Reset while the target drives a 0 bit of reg 5 (0xC3: third bit is 0)
    i2c_start();
    send_byte(8'h76, ack);
    send_byte(8'h05, ack);
    i2c_start();
    send_byte(8'h77, ack);
    tb_sda = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wq(); scl = 1'b1; wq(); wq(); scl = 1'b0;
    end
    repeat (8) @(negedge clk);
    chk("rr_driving_zero", sda_sel, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_released", sda_sel, 0);
    scl = 1'b1; tb_sda = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    i2c_start();
    send_byte(8'h76, ack); chk("rr_addr_ack", ack, 1);
    send_byte(8'h05, ack);
    i2c_start();
    send_byte(8'h77, ack);
    recv_byte(1'b1, rd);   chk("rr_reg5_cleared", rd, 8'h00);
    i2c_stop();

    // 2-clk SDA glitches while SCL high: no START in idle, no STOP mid-transfer
    repeat (10) @(negedge clk);
    tb_sda = 1'b0; repeat (2) @(negedge clk);
    tb_sda = 1'b1; repeat (20) @(negedge clk);
    chk("g_no_start", dut.state, 0);
    wr0 = wr_cnt;
    i2c_start();
    send_byte(8'h76, ack);
    send_byte(8'h06, ack);
    tb_sda = 1'b0; wq();
    scl = 1'b1;    wq();
    tb_sda = 1'b1; repeat (2) @(negedge clk);
    tb_sda = 1'b0; wq(); wq();
    chk("g_no_stop", busy, 1);
    tb_sda = 1'b1; wq(); wq();
    chk("g_stop_busy", busy, 0);
    chk("g_stop_idle", dut.state, 0);
    chk("g_no_partial_wr", wr_cnt - wr0, 0);
    scl = 1'b1;

    // Two data bytes at ptr 0x07
    wr0 = wr_cnt;
    i2c_start();
    send_byte(8'h76, ack);
    send_byte(8'h07, ack);
    send_byte(8'h11, ack); chk("b_d1_ack", ack, 1);
    send_byte(8'h22, ack); chk("b_d2_ack", ack, 1);
    i2c_stop();
    chk("b_wr_cnt", wr_cnt - wr0, 2);
    chk("b_last_data", last_data, 8'h22);
    i2c_start();
    send_byte(8'h76, ack);
    send_byte(8'h07, ack);
    i2c_start();
    send_byte(8'h77, ack);
    recv_byte(1'b0, rd);
`ifdef I2C_TARGET_AUTOINC_EN
    chk("b_last_addr", last_addr, 8'h08);
    chk("b_reg7", rd, 8'h11);
    recv_byte(1'b1, rd);
    chk("b_reg8", rd, 8'h22);
`else
    chk("b_last_addr", last_addr, 8'h07);
    chk("b_reg7_first", rd, 8'h22);
    recv_byte(1'b1, rd);
    chk("b_reg7_again", rd, 8'h22);
`endif
    i2c_stop();
    chk("b_busy_end", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
